// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller.
//   Arbitrates per-stage stall requests into stall[5:0] (bit0 PC .. bit5 WB),
//   turns a MEM-stage exception into a one-cycle flush plus redirect PC, and
//   freezes the whole pipeline while an instruction fetch is outstanding so
//   the flush is deferred until the fetch completes.
//
// Optional feature: define CTRL_STALL_WATCHDOG_EN to enable a watchdog that
//   raises sticky stall_timeout after WDOG_LIMIT consecutive PC-stall cycles.
//   Undefined: no counter, stall_timeout tied to 0.
//
// Ports:
//   clk           in   clock, all state updates on posedge
//   resetn        in   synchronous active-low reset
//   stallreq_if   in   IF stage waiting on instruction bus
//   stallreq_id   in   ID load-use hazard
//   stallreq_ex   in   EX multi-cycle op busy
//   stallreq_mem  in   MEM stage waiting on data bus
//   excepttype_i  in   MEM-stage exception code, 0 = none
//   cp0_epc_i     in   current EPC from CP0
//   stall         out  per-stage hold, 1 = hold
//   flush         out  one-cycle flush of all pipeline registers
//   new_pc        out  redirect PC, valid with flush
//   stall_cnt     out  saturating count of cycles with stall != 0
//   stall_timeout out  sticky watchdog flag
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE  = 32'h0000000E,
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt,
    output logic        stall_timeout
);

    typedef enum logic {RUN, WAIT_IF} state_t;

    state_t      state_q, state_d;
    logic [31:0] code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] stall_cnt_q;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        epc_d   = epc_q;
        stall   = '0;
        flush   = 1'b0;
        new_pc  = '0;
        if (resetn) begin
            unique case (state_q)
                RUN: begin
                    if (excepttype_i != '0) begin
                        if (stallreq_if) begin
                            // Fetch in flight: freeze everything and remember
                            // the exception until the bus transaction ends.
                            stall   = '1;
                            code_d  = excepttype_i;
                            epc_d   = cp0_epc_i;
                            state_d = WAIT_IF;
                        end else begin
                            flush  = 1'b1;
                            new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                        end
                    end else if (stallreq_mem) begin
                        stall = 6'b011111;
                    end else if (stallreq_ex) begin
                        stall = 6'b001111;
                    end else if (stallreq_id) begin
                        stall = 6'b000111;
                    end else if (stallreq_if) begin
                        stall = 6'b000011;
                    end
                end
                WAIT_IF: begin
                    if (stallreq_if) begin
                        stall = '1;
                    end else begin
                        flush   = 1'b1;
                        new_pc  = (code_q == ERET_CODE) ? epc_q : EXC_VECTOR;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= RUN;
            code_q      <= '0;
            epc_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            if (stall != '0 && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

`ifdef CTRL_STALL_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q;

    always_comb begin
        wdog_d = '0;
        if (stall[0])
            wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_q | (wdog_d == WDOG_MAX);
        end
    end

    assign stall_timeout = timeout_q;
`else
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;
    logic        stall_timeout;

    int n_cmp = 0;
    int n_err = 0;

`ifdef CTRL_STALL_WATCHDOG_EN
    localparam logic WD_ON = 1'b1;
`else
    localparam logic WD_ON = 1'b0;
`endif

    pipe_ctrl #(
        .EXC_VECTOR(32'hBFC00380),
        .ERET_CODE (32'h0000000E),
        .WDOG_LIMIT(16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cnt    (stall_cnt),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs after the falling edge; outputs are then
    // observed 1 ns later, well away from the next rising edge.
    task automatic drive(input logic rn, input logic rif, input logic rid,
                         input logic rex, input logic rmem,
                         input logic [31:0] exc, input logic [31:0] epc);
        @(negedge clk);
        resetn       = rn;
        stallreq_if  = rif;
        stallreq_id  = rid;
        stallreq_ex  = rex;
        stallreq_mem = rmem;
        excepttype_i = exc;
        cp0_epc_i    = epc;
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h1234_5678);
            n_cmp++;
            if (stall !== 6'b0 || flush !== 1'b0 || new_pc !== 32'h0) begin
                n_err++;
                $display("FAIL reset_outputs: stall=%b flush=%b new_pc=%h, required 000000/0/00000000",
                         stall, flush, new_pc);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (stall_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_stall_cnt: got %0d, required 0", stall_cnt);
        end
        n_cmp++;
        if (stall !== 6'b0 || flush !== 1'b0 || new_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_release: stall=%b flush=%b new_pc=%h, required idle", stall, flush, new_pc);
        end
    endtask

    task automatic test_priority;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        n_cmp++;
        if (stall !== 6'b011111 || flush !== 1'b0) begin
            n_err++;
            $display("FAIL prio_mem_id: stall=%b flush=%b, required 011111/0", stall, flush);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (stall !== 6'b000111) begin
            n_err++;
            $display("FAIL prio_id: stall=%b, required 000111", stall);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (stall !== 6'b000011) begin
            n_err++;
            $display("FAIL prio_if: stall=%b, required 000011", stall);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (stall !== 6'b001111) begin
            n_err++;
            $display("FAIL prio_ex: stall=%b, required 001111", stall);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (stall !== 6'b0 || stall_cnt !== 32'd4) begin
            n_err++;
            $display("FAIL prio_idle_cnt: stall=%b cnt=%0d, required 000000/4", stall, stall_cnt);
        end
    endtask

    task automatic test_exception;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8, 32'h8000_0000);
        n_cmp++;
        if (flush !== 1'b1 || stall !== 6'b0 || new_pc !== 32'hBFC00380) begin
            n_err++;
            $display("FAIL exc_immediate: flush=%b stall=%b new_pc=%h, required 1/000000/bfc00380",
                     flush, stall, new_pc);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8000_0000);
        n_cmp++;
        if (flush !== 1'b0 || new_pc !== 32'h0 || stall_cnt !== 32'd4) begin
            n_err++;
            $display("FAIL exc_after: flush=%b new_pc=%h cnt=%0d, required 0/00000000/4",
                     flush, new_pc, stall_cnt);
        end
    endtask

    task automatic test_eret;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hE, 32'h8000_1234);
        n_cmp++;
        if (flush !== 1'b1 || stall !== 6'b0 || new_pc !== 32'h8000_1234) begin
            n_err++;
            $display("FAIL eret: flush=%b stall=%b new_pc=%h, required 1/000000/80001234",
                     flush, stall, new_pc);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_deferred;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC, 32'h1111_2222);
        n_cmp++;
        if (stall !== 6'b111111 || flush !== 1'b0) begin
            n_err++;
            $display("FAIL defer_enter: stall=%b flush=%b, required 111111/0", stall, flush);
        end
        // Other stall requests are present but must be ignored while frozen.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
            n_cmp++;
            if (stall !== 6'b111111 || flush !== 1'b0) begin
                n_err++;
                $display("FAIL defer_hold: stall=%b flush=%b, required 111111/0", stall, flush);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (flush !== 1'b1 || stall !== 6'b0 || new_pc !== 32'hBFC00380) begin
            n_err++;
            $display("FAIL defer_flush: flush=%b stall=%b new_pc=%h, required 1/000000/bfc00380",
                     flush, stall, new_pc);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (flush !== 1'b0 || stall_cnt !== 32'd8) begin
            n_err++;
            $display("FAIL defer_after: flush=%b cnt=%0d, required 0/8", flush, stall_cnt);
        end
    endtask

    task automatic test_deferred_eret;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hE, 32'hA000_0040);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        n_cmp++;
        if (stall !== 6'b111111) begin
            n_err++;
            $display("FAIL defer_eret_hold: stall=%b, required 111111", stall);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h5555_5555);
        n_cmp++;
        if (flush !== 1'b1 || new_pc !== 32'hA000_0040) begin
            n_err++;
            $display("FAIL defer_eret_flush: flush=%b new_pc=%h, required 1/a0000040", flush, new_pc);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (stall_cnt !== 32'd10 || flush !== 1'b0) begin
            n_err++;
            $display("FAIL defer_eret_cnt: cnt=%0d flush=%b, required 10/0", stall_cnt, flush);
        end
    endtask

    task automatic test_reset_mid_wait;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (stall !== 6'b0 || flush !== 1'b0) begin
            n_err++;
            $display("FAIL midwait_reset_out: stall=%b flush=%b, required 000000/0", stall, flush);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (flush !== 1'b0 || stall !== 6'b0 || new_pc !== 32'h0 || stall_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL midwait_discard: flush=%b stall=%b new_pc=%h cnt=%0d, required 0/000000/0/0",
                     flush, stall, new_pc, stall_cnt);
        end
    endtask

    task automatic test_watchdog;
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (stall_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL wdog_15: timeout=%b, required 0", stall_timeout);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            if (i == 15) begin
                n_cmp++;
                if (stall_timeout !== 1'b0 || stall !== 6'b001111) begin
                    n_err++;
                    $display("FAIL wdog_pre: timeout=%b stall=%b, required 0/001111", stall_timeout, stall);
                end
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (stall_timeout !== WD_ON || stall_cnt !== 32'd31) begin
            n_err++;
            $display("FAIL wdog_16: timeout=%b cnt=%0d, required %b/31", stall_timeout, stall_cnt, WD_ON);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (stall_timeout !== WD_ON) begin
            n_err++;
            $display("FAIL wdog_sticky: timeout=%b, required %b", stall_timeout, WD_ON);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (stall_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL wdog_reset: timeout=%b, required 0", stall_timeout);
        end
    endtask

    initial begin
        resetn = 1'b0;
        stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        excepttype_i = '0; cp0_epc_i = '0;
        test_reset();
        test_priority();
        test_exception();
        test_eret();
        test_deferred();
        test_deferred_eret();
        test_reset_mid_wait();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller that drives the stall[5:0] and flush inputs consumed by every inter-stage register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
- Arbitrates per-stage stall requests.
- Converts a MEM-stage exception into a one-cycle flush plus redirect PC.
- Defers the flush while an instruction-fetch bus transaction is outstanding, freezing the whole pipeline until the fetch completes.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions except ERET.
ERET_CODE, 32'h0000000E, excepttype value that selects cp0_epc_i as target.
WDOG_LIMIT, 1024, consecutive PC-stall cycles before timeout (used only with the optional feature).

Ports:
clk  in  1  clock; all state updates on posedge.
resetn  in  1  synchronous reset, active-low.
stallreq_if  in  1  IF stage waiting on instruction bus.
stallreq_id  in  1  ID load-use hazard.
stallreq_ex  in  1  EX multi-cycle op (mult/div) busy.
stallreq_mem  in  1  MEM stage waiting on data bus.
excepttype_i  in  32  MEM-stage final exception code; 0 = none.
cp0_epc_i  in  32  current EPC from CP0.
stall  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = hold.
flush  out  1  one-cycle flush of all pipeline registers.
new_pc  out  32  redirect PC, valid when flush=1.
stall_cnt  out  32  saturating count of cycles with stall!=0.
stall_timeout  out  1  sticky watchdog flag (optional feature).

Behaviour:
States: RUN, WAIT_IF.

Reset (resetn=0 at posedge):
- state=RUN; latched code/EPC=0; stall_cnt=0; watchdog count/flag=0.
- While resetn=0, combinational outputs are forced: stall=0, flush=0, new_pc=0.

RUN, excepttype_i!=0, stallreq_if=0:
- flush=1, stall=6'b000000 in the same cycle (combinational).
- new_pc = cp0_epc_i if excepttype_i==ERET_CODE, else EXC_VECTOR.
- Stay in RUN.

RUN, excepttype_i!=0, stallreq_if=1:
- flush=0, stall=6'b111111.
- Latch excepttype_i and cp0_epc_i; go to WAIT_IF at the next edge.

RUN, excepttype_i==0: stall by fixed priority; flush=0, new_pc=0.
- stallreq_mem -> 6'b011111
- else stallreq_ex -> 6'b001111
- else stallreq_id -> 6'b000111
- else stallreq_if -> 6'b000011
- else 6'b000000

WAIT_IF:
- stall=6'b111111 and flush=0 while stallreq_if=1.
- The cycle stallreq_if=0: flush=1, stall=0, new_pc computed from the latched code/EPC (same rule as above); return to RUN.
- excepttype_i and other stall requests are ignored in WAIT_IF, because the pipeline is frozen and the MEM stage holds its value.

Flush properties:
- flush is never asserted on two consecutive cycles from a single exception, since the flushed EX_MEM returns excepttype 0.
- Flush and stall are mutually exclusive in every cycle.

stall_cnt: increments when stall!=0 at a posedge; saturates at 32'hFFFFFFFF; not cleared by flush.

Reset mid-WAIT_IF: returns to RUN; the pending exception is discarded.

Optional Feature:
CTRL_STALL_WATCHDOG_EN.
- Defined:
  - An 11-bit (ceil log2 WDOG_LIMIT+1) counter counts consecutive posedges with stall[0]=1 and clears on any cycle with stall[0]=0.
  - When it reaches WDOG_LIMIT, stall_timeout goes to 1 and stays 1 until reset; the counter holds at the limit.
  - Watchdog does not alter stall or flush.
- Undefined: the counter is absent and stall_timeout is tied to 0.

Test Plan:
1. Reset: hold resetn=0 for 3 cycles with all stallreq=1 and excepttype_i=8 -> stall=0, flush=0, new_pc=0, stall_cnt=0 after release.
2. Priority: stallreq_id=1 and stallreq_mem=1 together -> stall=6'b011111; drop mem -> 6'b000111; drop id, raise if -> 6'b000011.
3. Exception immediate: excepttype_i=32'h8, stallreq_if=0 -> flush=1 for exactly that cycle, new_pc=32'hBFC00380, stall=0; next cycle (excepttype 0) flush=0.
4. ERET: excepttype_i=32'hE, cp0_epc_i=32'h8000_1234 -> flush=1, new_pc=32'h8000_1234.
5. Deferred: excepttype_i=32'hC with stallreq_if=1 for 4 cycles, excepttype_i changed to 0 after the first cycle:
   - stall=6'b111111 for 4 cycles.
   - Then one cycle flush=1, new_pc=32'hBFC00380, stall=0.
   - stall_cnt rises by 4.
6. With CTRL_STALL_WATCHDOG_EN and WDOG_LIMIT=16: stallreq_ex=1 for 15 cycles then 0 -> stall_timeout=0; stallreq_ex=1 for 16 cycles -> stall_timeout=1 and stays 1 after the request drops, until resetn=0.
